// File: rtl/pcie_ss_axis_wrr_arbiter.sv
// Weighted round-robin, packet-atomic arbiter over NUM_CH PCIe SS AXI-S request channels.
// Latency: zero-cycle grant from in_valid/in_last and registered turn state; state moves on accepted beats.
// Backpressure: with advance low nothing changes and the grant holds; a locked packet pins the grant.
module pcie_ss_axis_wrr_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int WEIGHT_W = 4,
  parameter int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH-1:0]          in_last,
  input  logic                       advance,
  input  logic [NUM_CH*WEIGHT_W-1:0] weight,
  output logic                       out_valid,
  output logic [SEL_W-1:0]           out_select,
  output logic [NUM_CH-1:0]          out_select_1hot,
  output logic                       locked
);

  // Turn owner, packets left in the turn, and in-flight packet pinning.
  logic [SEL_W-1:0]    cur_q,     cur_d;
  logic [WEIGHT_W-1:0] credit_q,  credit_d;
  logic                lock_q,    lock_d;
  logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;

  logic [SEL_W-1:0]    grant;
  logic                grant_vld;
  logic [WEIGHT_W-1:0] grant_weight;
  logic                accept;

  // Pick the granted channel: pinned owner, then continuing turn, then rotation from cur+1.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    found     = 1'b0;
    if (lock_q) begin
      grant     = lock_ch_q;
      grant_vld = in_valid[lock_ch_q];
    end else if (in_valid[cur_q] && (credit_q != '0)) begin
      grant     = cur_q;
      grant_vld = 1'b1;
    end else begin
      // cur itself is the last candidate (k == NUM_CH wraps back onto it).
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = int'(cur_q) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && in_valid[idx]) begin
          found     = 1'b1;
          grant     = SEL_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Weight of the granted channel, only consumed when it starts a new turn.
  always_comb begin
    grant_weight = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant == SEL_W'(c)) grant_weight = weight[c*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign accept = grant_vld & advance;

  // Next-state: charge or reload turn credit at packet start, track lock on every accepted beat.
  always_comb begin
    cur_d     = cur_q;
    credit_d  = credit_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (accept) begin
      if (!lock_q) begin
        if ((grant == cur_q) && (credit_q != '0)) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          // A zero weight behaves as one packet per turn.
          cur_d    = grant;
          credit_d = (grant_weight == '0) ? '0 : grant_weight - WEIGHT_W'(1);
        end
      end
      lock_d    = ~in_last[grant];
      lock_ch_d = grant;
    end
  end

  // State registers; reset places cur on the last channel so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q     <= SEL_W'(NUM_CH - 1);
      credit_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      cur_q     <= cur_d;
      credit_q  <= credit_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Outputs are forced to zero when nothing is granted so tready terms stay quiet.
  always_comb begin
    out_valid       = grant_vld;
    out_select      = grant_vld ? grant : '0;
    out_select_1hot = '0;
    if (grant_vld) out_select_1hot[grant] = 1'b1;
    locked          = lock_q;
  end

endmodule

// File: tb/tb_pcie_ss_axis_wrr_arbiter.sv
// Directed bench for the weighted round-robin packet arbiter.
// Latency: checks outputs on the falling edge, state commits on the rising edge.
// Backpressure: exercises advance=0 holds and locked-channel idle cycles.
module tb_pcie_ss_axis_wrr_arbiter;

  localparam int NUM_CH   = 4;
  localparam int WEIGHT_W = 4;
  localparam int SEL_W    = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_CH-1:0]          in_valid;
  logic [NUM_CH-1:0]          in_last;
  logic                       advance;
  logic [NUM_CH*WEIGHT_W-1:0] weight;
  logic                       out_valid;
  logic [SEL_W-1:0]           out_select;
  logic [NUM_CH-1:0]          out_select_1hot;
  logic                       locked;

  int n_checks = 0;
  int n_fail   = 0;

  pcie_ss_axis_wrr_arbiter #(
    .NUM_CH   (NUM_CH),
    .WEIGHT_W (WEIGHT_W),
    .SEL_W    (SEL_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .advance         (advance),
    .weight          (weight),
    .out_valid       (out_valid),
    .out_select      (out_select),
    .out_select_1hot (out_select_1hot),
    .locked          (locked)
  );

  always #5 clk = ~clk;

  // Move to the sampling point for the current inputs.
  task automatic sample();
    @(negedge clk);
  endtask

  // Let the current inputs commit, then drive new ones just after the edge.
  task automatic commit();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = '0; in_last = '0; advance = 1'b1; weight = 16'h1111;
    apply_reset();
    sample();
    n_checks++;
    if (out_valid !== 1'b0 || out_select !== 2'd0 || out_select_1hot !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b sel=%0d oh=%b, want 0 0 0000", out_valid, out_select, out_select_1hot);
    end
    n_checks++;
    if (locked !== 1'b0 || dut.cur_q !== 2'd3 || dut.credit_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got locked=%b cur=%0d credit=%0d, want 0 3 0", locked, dut.cur_q, dut.credit_q);
    end
    commit();
  endtask

  task automatic test_weighted_rotation();
    logic [1:0] exp_seq [10];
    exp_seq = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    weight = 16'h1112;
    in_valid = '0; in_last = '0; advance = 1'b1;
    apply_reset();
    in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      sample();
      n_checks++;
      if (out_valid !== 1'b1 || out_select !== exp_seq[i] || out_select_1hot !== (4'b0001 << exp_seq[i])) begin
        n_fail++;
        $display("FAIL wrr_seq[%0d]: got vld=%b sel=%0d oh=%b, want 1 %0d", i, out_valid, out_select, out_select_1hot, exp_seq[i]);
      end
      commit();
    end
  endtask

  task automatic test_multibeat_lock();
    logic [1:0] exp_sel [5];
    logic       exp_lck [5];
    logic       last1   [5];
    exp_sel = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    exp_lck = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    last1   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    weight = 16'h1111;
    in_valid = '0; in_last = '0; advance = 1'b1;
    apply_reset();
    in_valid = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      in_last = {1'b1, 1'b1, last1[i], 1'b1};
      sample();
      n_checks++;
      if (out_valid !== 1'b1 || out_select !== exp_sel[i] || locked !== exp_lck[i]) begin
        n_fail++;
        $display("FAIL multibeat[%0d]: got vld=%b sel=%0d locked=%b, want 1 %0d %b", i, out_valid, out_select, locked, exp_sel[i], exp_lck[i]);
      end
      commit();
    end
  endtask

  task automatic test_advance_hold();
    weight = 16'h1211;
    in_valid = '0; in_last = '0; advance = 1'b1;
    apply_reset();
    in_valid = 4'b0100; in_last = 4'b1111;
    commit();
    advance = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      n_checks++;
      if (out_valid !== 1'b1 || out_select !== 2'd2 || out_select_1hot !== 4'b0100) begin
        n_fail++;
        $display("FAIL hold_sel[%0d]: got vld=%b sel=%0d oh=%b, want 1 2 0100", i, out_valid, out_select, out_select_1hot);
      end
      commit();
    end
    n_checks++;
    if (dut.cur_q !== 2'd2 || dut.credit_q !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_state: got cur=%0d credit=%0d, want 2 1", dut.cur_q, dut.credit_q);
    end
    advance = 1'b1;
    sample();
    n_checks++;
    if (out_select !== 2'd2) begin
      n_fail++;
      $display("FAIL hold_resume_sel: got %0d, want 2", out_select);
    end
    commit();
    n_checks++;
    if (dut.credit_q !== 4'd0 || dut.cur_q !== 2'd2) begin
      n_fail++;
      $display("FAIL hold_resume_state: got cur=%0d credit=%0d, want 2 0", dut.cur_q, dut.credit_q);
    end
  endtask

  task automatic test_zero_weight();
    weight = 16'h0111;
    in_valid = '0; in_last = '0; advance = 1'b1;
    apply_reset();
    in_valid = 4'b1000; in_last = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      sample();
      n_checks++;
      if (out_valid !== 1'b1 || out_select !== 2'd3) begin
        n_fail++;
        $display("FAIL zero_wt_sel[%0d]: got vld=%b sel=%0d, want 1 3", i, out_valid, out_select);
      end
      commit();
      n_checks++;
      if (dut.credit_q !== 4'd0 || dut.cur_q !== 2'd3) begin
        n_fail++;
        $display("FAIL zero_wt_state[%0d]: got cur=%0d credit=%0d, want 3 0", i, dut.cur_q, dut.credit_q);
      end
    end
  endtask

  task automatic test_lock_idle();
    weight = 16'h1111;
    in_valid = '0; in_last = '0; advance = 1'b1;
    apply_reset();
    in_valid = 4'b0011; in_last = 4'b0010;
    sample();
    n_checks++;
    if (out_select !== 2'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_first: got vld=%b sel=%0d, want 1 0", out_valid, out_select);
    end
    commit();
    in_valid = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_checks++;
      if (out_valid !== 1'b0 || out_select_1hot !== 4'b0000 || out_select !== 2'd0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: got vld=%b sel=%0d oh=%b locked=%b, want 0 0 0000 1", i, out_valid, out_select, out_select_1hot, locked);
      end
      commit();
    end
    in_valid = 4'b0011; in_last = 4'b0011;
    sample();
    n_checks++;
    if (out_valid !== 1'b1 || out_select !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_resume: got vld=%b sel=%0d, want 1 0", out_valid, out_select);
    end
    commit();
    sample();
    n_checks++;
    if (out_valid !== 1'b1 || out_select !== 2'd1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_next: got vld=%b sel=%0d locked=%b, want 1 1 0", out_valid, out_select, locked);
    end
    commit();
  endtask

  task automatic test_reset_mid_packet();
    weight = 16'h1111;
    in_valid = '0; in_last = '0; advance = 1'b1;
    apply_reset();
    in_valid = 4'b0100; in_last = 4'b0000;
    commit();
    sample();
    n_checks++;
    if (locked !== 1'b1 || out_select !== 2'd2) begin
      n_fail++;
      $display("FAIL rstmid_locked: got locked=%b sel=%0d, want 1 2", locked, out_select);
    end
    rst = 1'b1;
    commit();
    rst = 1'b0;
    in_valid = 4'b0101; in_last = 4'b0101;
    sample();
    n_checks++;
    if (locked !== 1'b0 || dut.cur_q !== 2'd3) begin
      n_fail++;
      $display("FAIL rstmid_state: got locked=%b cur=%0d, want 0 3", locked, dut.cur_q);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_select !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_grant: got vld=%b sel=%0d, want 1 0", out_valid, out_select);
    end
    commit();
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; advance = 1'b0; weight = '0;
    commit();
    test_reset();
    test_weighted_rotation();
    test_multibeat_lock();
    test_advance_hold();
    test_zero_weight();
    test_lock_idle();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
